// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed hex display scanner:
// segment type, hex segment table, blank pattern and index-width helper.
package display_pkg;

  // Segment vector indexed [0:6] = segments a..g, active-low (0 = lit).
  typedef logic [0:6] seg_t;

  // All segments off.
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low segment patterns for nibble values 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // Bits needed to hold a digit index 0..n-1. Never returns less than 1,
  // so a single-digit display still gets a real (always zero) index bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment lookup.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scanner.sv
// Multiplexed hex display scanner: prescaled digit rotation, frame-aligned
// (tear-free) display loading, leading-zero blanking and registered outputs.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] entrada,
  input  logic                    carga,
  input  logic                    apaga_zeros,
  input  logic [NUM_DIGITS-1:0]   pontos,
  output logic [0:6]              saida,
  output logic                    ponto,
  output logic [NUM_DIGITS-1:0]   anodos
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [IW-1:0] index_reg, index_next;
  logic [DW-1:0] display_reg, display_next;
  logic [DW-1:0] pending_reg, pending_next;
  logic          pend_flag_reg, pend_flag_next;

  logic wrap;
  logic frame_end;

  assign wrap      = (presc_reg == PRESC_LAST);
  assign frame_end = wrap && (index_reg == INDEX_LAST);

  // Next-state: prescaler, digit index, and the pending/display handoff that
  // only ever touches the display register on the frame boundary.
  always_comb begin
    presc_next     = wrap ? '0 : presc_reg + PW'(1);
    index_next     = index_reg;
    display_next   = display_reg;
    pending_next   = pending_reg;
    pend_flag_next = pend_flag_reg;
    if (wrap) begin
      index_next = (index_reg == INDEX_LAST) ? '0 : index_reg + IW'(1);
    end
    if (frame_end) begin
      // A load on the boundary cycle bypasses pending and is newest of all.
      pend_flag_next = 1'b0;
      if (carga) begin
        display_next = entrada;
      end else if (pend_flag_reg) begin
        display_next = pending_reg;
      end
    end else if (carga) begin
      pending_next   = entrada;
      pend_flag_next = 1'b1;
    end
  end

  // Scan and load state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_reg     <= '0;
      index_reg     <= '0;
      display_reg   <= '0;
      pending_reg   <= '0;
      pend_flag_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      index_reg     <= index_next;
      display_reg   <= display_next;
      pending_reg   <= pending_next;
      pend_flag_reg <= pend_flag_next;
    end
  end

  // Per-digit nibbles and "this nibble and everything above it is zero".
  logic [3:0]            nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibbles[gi]    = display_reg[4*gi +: 4];
      assign upper_zero[gi] = (display_reg[DW-1:4*gi] == '0);
    end
  endgenerate

  logic [3:0]            cur_nibble;
  logic                  blank_cur;
  seg_t                  seg_lut;
  seg_t                  saida_next;
  logic                  ponto_next;
  logic [NUM_DIGITS-1:0] anodos_next;

  assign cur_nibble = nibbles[index_reg];
  // Digit 0 always shows something, even when the whole value is zero.
  assign blank_cur  = apaga_zeros && (index_reg != '0) && upper_zero[index_reg];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_nibble),
    .seg (seg_lut)
  );

  assign saida_next  = blank_cur ? SEG_BLANK : seg_lut;
  assign ponto_next  = ~pontos[index_reg];
  assign anodos_next = ~(NUM_DIGITS'(1) << index_reg);

  // Registered outputs; dark while in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida  <= SEG_BLANK;
      ponto  <= 1'b1;
      anodos <= '1;
    end else begin
      saida  <= saida_next;
      ponto  <= ponto_next;
      anodos <= anodos_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with NUM_DIGITS=4, SCAN_DIV=4.
module tb_display_scanner;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] entrada = '0;
  logic        carga = 1'b0;
  logic        apaga_zeros = 1'b0;
  logic [3:0]  pontos = '0;
  logic [0:6]  saida;
  logic        ponto;
  logic [3:0]  anodos;

  int vec_count  = 0;
  int miss_count = 0;

  display_scanner #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .entrada     (entrada),
    .carga       (carga),
    .apaga_zeros (apaga_zeros),
    .pontos      (pontos),
    .saida       (saida),
    .ponto       (ponto),
    .anodos      (anodos)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic load(input logic [15:0] v);
    entrada = v;
    carga   = 1'b1;
    @(negedge clock);
    carga   = 1'b0;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] an);
    int n;
    n = 0;
    while (anodos !== an && n < 64) begin
      @(negedge clock);
      n++;
    end
    check_vec(tag, anodos, an);
  endtask

  // Wait for digit k to be enabled, check it, then wait until it is released.
  task automatic show_digit(input string tag, input int k, input logic [6:0] seg, input logic pt);
    logic [3:0] an;
    int n;
    an = ~(4'b0001 << k);
    wait_an($sformatf("%s_d%0d_an", tag, k), an);
    check_vec($sformatf("%s_d%0d_seg", tag, k), saida, seg);
    check_vec($sformatf("%s_d%0d_pt", tag, k), ponto, pt);
    n = 0;
    while (anodos === an && n < 64) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic scan_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] pt);
    show_digit(tag, 0, s0, ~pt[0]);
    show_digit(tag, 1, s1, ~pt[1]);
    show_digit(tag, 2, s2, ~pt[2]);
    show_digit(tag, 3, s3, ~pt[3]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0] an;

    // Dark while in reset.
    repeat (2) @(negedge clock);
    check_vec("rst_seg", saida, SB);
    check_vec("rst_pt", ponto, 1'b1);
    check_vec("rst_an", anodos, 4'b1111);

    // First edge after release drives digit 0 showing 0.
    reset = 1'b0;
    @(negedge clock);
    check_vec("first_an", anodos, 4'b1110);
    check_vec("first_seg", saida, S0);

    // Each digit held for SCAN_DIV cycles, in order 0..3.
    for (int k = 0; k < 4; k++) begin
      an = ~(4'b0001 << k);
      n  = 0;
      check_vec($sformatf("scan_d%0d_seg", k), saida, S0);
      while (anodos === an && n < 20) begin
        n++;
        @(negedge clock);
      end
      check_vec($sformatf("scan_d%0d_hold", k), n, 4);
    end

    // Mid-frame load waits for the next frame.
    load(16'h12AF);
    scan_frame("hold", S0, S0, S0, S0, 4'b0000);
    scan_frame("new", SF, SA, S2, S1, 4'b0000);

    // Leading-zero blanking plus a live decimal point on digit 2.
    apaga_zeros = 1'b1;
    pontos      = 4'b0100;
    load(16'h0050);
    scan_frame("prev", SF, SA, S2, S1, 4'b0100);
    scan_frame("blank", S0, S5, SB, SB, 4'b0100);

    // Two mid-frame loads then a load on the boundary cycle itself.
    load(16'h1111);
    wait_an("bnd_w1", 4'b1101);
    load(16'h2222);
    wait_an("bnd_w3", 4'b0111);
    repeat (2) @(negedge clock);
    load(16'h3333);
    scan_frame("bnd", S3, S3, S3, S3, 4'b0100);
    scan_frame("bnd2", S3, S3, S3, S3, 4'b0100);

    // Reset during digit 2 after a load discards everything.
    apaga_zeros = 1'b0;
    load(16'h5678);
    wait_an("mr_w2", 4'b1011);
    reset = 1'b1;
    #1;
    check_vec("mr_seg", saida, SB);
    check_vec("mr_pt", ponto, 1'b1);
    check_vec("mr_an", anodos, 4'b1111);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_vec("mr_first_an", anodos, 4'b1110);
    check_vec("mr_first_seg", saida, S0);
    scan_frame("mr", S0, S0, S0, S0, 4'b0100);
    scan_frame("mr2", S0, S0, S0, S0, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit stays enabled, legal range >= 2.
REQ-003 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port entrada  input  4*NUM_DIGITS: hex value; nibble k drives digit k, digit 0 is least significant.
REQ-006 Port carga  input  1: load strobe; entrada is captured on a clock edge where carga=1.
REQ-007 Port apaga_zeros  input  1: 1 enables leading-zero blanking.
REQ-008 Port pontos  input  NUM_DIGITS: decimal point request per digit, 1=lit; sampled live, not through carga.
REQ-009 Port saida  output  7, indexed [0:6] = segments a..g: segment pattern, active-low (0 = lit).
REQ-010 Port ponto  output  1: decimal point, active-low.
REQ-011 Port anodos  output  NUM_DIGITS: digit enables, active-low, one-hot-low while scanning.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; the digit index increments on the wrap cycle, modulo NUM_DIGITS.
REQ-013 Outputs saida, ponto and anodos are registered and reflect the digit index and display register one cycle after they change.
REQ-014 Digit encoding for nibble 0..F (saida[0:6]): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-015 carga=1 writes entrada into a pending register and sets a pending flag; if carga is asserted several times within a frame, the last value wins.
REQ-016 At the frame boundary (index wraps NUM_DIGITS-1 -> 0), if the pending flag is set, pending is copied into the display register and the flag is cleared; the display register never changes mid-frame (no tearing).
REQ-017 If carga=1 on the frame-boundary cycle, that entrada value is written directly into the display register and the flag is left cleared.
REQ-018 With apaga_zeros=1, digit k>0 is blanked (saida=1111111) when nibble k and all more-significant nibbles are zero; digit 0 is never blanked.
REQ-019 A blanked digit still drives its anodo low; ponto follows pontos[k] regardless of blanking.
REQ-020 apaga_zeros and pontos take effect at the next registered output update, with no frame alignment.
REQ-021 NUM_DIGITS=1: index stays 0; the frame boundary is every prescaler wrap.

Reset
REQ-022 While reset=1: prescaler=0, index=0, display and pending registers=0, pending flag=0.
REQ-023 While reset=1: saida=1111111, ponto=1, anodos all ones (display dark).
REQ-024 Reset asserted mid-frame or mid-load discards pending data; the first clock edge after release drives digit 0 showing "0".

Structure
REQ-025 Shared package display_pkg holds the 16-entry segment table, the SEG_BLANK constant (1111111) and the digit-index width function clog2(NUM_DIGITS).
REQ-026 Hex-to-segment lookup is a combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated once, fed by the nibble muxed from the current index.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-027 Reset release, no load -> anodos cycles 1110,1101,1011,0111, each held 4 cycles; saida=0000001 on every digit.
REQ-028 carga with entrada=16'h12AF mid-frame -> current frame unchanged; next frame shows F,A,2,1 on digits 0..3 (0111000, 0001000, 0010010, 1001111).
REQ-029 entrada=16'h0050, apaga_zeros=1 -> digits 2,3 show 1111111 with anodo still low; digit 1 shows 0100100; digit 0 shows 0000001.
REQ-030 Two carga pulses (16'h1111 then 16'h2222) in one frame, plus a carga of 16'h3333 on the boundary cycle -> the display register goes straight to 3333; 1111 and 2222 are never displayed.
REQ-031 Reset pulse during digit 2 after a load -> outputs dark during reset; after release, scan restarts at digit 0 showing 0000.
REQ-032 pontos=4'b0100 -> ponto=0 only while anodos=1011, including while digit 2 is blanked.
